// File: rtl/fsmc_pkg.sv
// -----------------------------------------------------------------------------
// fsmc_pkg
//   Shared types and constants for the FSMC bus initiator (fsmc_master).
//   - fsmc_state_t : bus-cycle state encoding
//   - DEF_*        : default bus geometry and per-phase cycle counts
//   - DEF_AD_PAD_WIDTH : zero bits above the data field when data is placed
//                        on the multiplexed AD bus
//   - phase_cnt_width(): phase counter width for a given largest phase length
// -----------------------------------------------------------------------------
package fsmc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    AHOLD = 3'd2,
    DATA  = 3'd3,
    TURN  = 3'd4
  } fsmc_state_t;

  localparam int DEF_ADDR_WIDTH     = 18;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_ADDSET_CYCLES  = 2;
  localparam int DEF_ADDHLD_CYCLES  = 1;
  localparam int DEF_DATAST_CYCLES  = 4;
  localparam int DEF_BUSTURN_CYCLES = 1;

  // Data rides on AD[DATA_WIDTH-1:0]; the upper bits are driven as zero.
  localparam int DEF_AD_PAD_WIDTH = DEF_ADDR_WIDTH - DEF_DATA_WIDTH;

  // Counter must hold the largest (N-1) load value; one spare bit keeps
  // the width sane for power-of-two lengths and for N=1.
  function automatic int phase_cnt_width(input int max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// -----------------------------------------------------------------------------
// fsmc_phase_timer
//   Loadable down-counter shared by all bus phases. The FSM loads N-1 when it
//   enters a phase and leaves the phase in the cycle where done_o is high.
//   Ports:
//     clk        : clock
//     rst        : asynchronous reset, active-high (counter clears to 0)
//     load_i     : load load_val_i this cycle
//     load_val_i : value to load (phase length - 1)
//     done_o     : counter is zero (last cycle of the current phase)
// -----------------------------------------------------------------------------
module fsmc_phase_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fsmc_master.sv
// -----------------------------------------------------------------------------
// fsmc_master
//   Synchronous FSMC initiator for address/data-multiplexed NOR/PSRAM-style
//   single-beat transactions. A request accepted in cycle 0 produces:
//     ADDR  (NE=0, NADV=0, AD=address)       ADDSET_CYCLES
//     AHOLD (NE=0, NADV=1, AD=address)       ADDHLD_CYCLES
//     DATA  (NWE=0 + AD=data, or NOE=0 + AD released)  DATAST_CYCLES
//     TURN  (all strobes high, AD released)  BUSTURN_CYCLES (0 = skipped)
//   followed by a one-cycle rsp_valid pulse in IDLE.
//
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high; req_ready is high only in IDLE outside reset and
//   request fields are ignored at all other times. rsp_valid is a single-cycle
//   strobe with no back-pressure.
//
//   Every bus pin and the AD output enable come straight from flops, whose
//   next values are decoded from the next FSM state.
//
//   Optional build macro FSMC_MASTER_RDSYNC_EN: AD is registered before read
//   capture, and capture happens in the cycle after DATA (requires
//   BUSTURN_CYCLES >= 1 so the data still lands before rsp_valid).
//
//   Ports:
//     clk, reset           : clock, asynchronous active-high reset
//     req_valid/req_ready  : request handshake
//     req_write            : 1 = write, 0 = read
//     req_addr, req_wdata  : request address / write data
//     rsp_valid            : one-cycle completion pulse
//     rsp_rdata            : last read data, held until the next read
//     busy                 : acceptance through the rsp_valid cycle
//     NE, NADV, NWE, NOE   : active-low bus strobes
//     AD                   : multiplexed address/data bus
// -----------------------------------------------------------------------------
module fsmc_master
  import fsmc_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDSET_CYCLES  = DEF_ADDSET_CYCLES,
  parameter int ADDHLD_CYCLES  = DEF_ADDHLD_CYCLES,
  parameter int DATAST_CYCLES  = DEF_DATAST_CYCLES,
  parameter int BUSTURN_CYCLES = DEF_BUSTURN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  NE,
  output logic                  NADV,
  output logic                  NWE,
  output logic                  NOE,
  inout  wire  [ADDR_WIDTH-1:0] AD
);

  localparam int MAX_PHASE = max4(ADDSET_CYCLES, ADDHLD_CYCLES, DATAST_CYCLES, BUSTURN_CYCLES);
  localparam int CW        = phase_cnt_width(MAX_PHASE);
  localparam int AD_PAD_W  = ADDR_WIDTH - DATA_WIDTH;

  localparam logic [CW-1:0] LD_ADDSET  = CW'(ADDSET_CYCLES - 1);
  localparam logic [CW-1:0] LD_ADDHLD  = CW'(ADDHLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_DATAST  = CW'(DATAST_CYCLES - 1);
  localparam logic [CW-1:0] LD_BUSTURN = (BUSTURN_CYCLES > 0) ? CW'(BUSTURN_CYCLES - 1) : '0;
  localparam bit            HAS_TURN   = (BUSTURN_CYCLES > 0);

  // Elaboration-time sanity checks on the timing parameters.
  if (ADDSET_CYCLES < 1 || ADDHLD_CYCLES < 1 || DATAST_CYCLES < 1) begin : g_bad_phase
    $error("fsmc_master: ADDSET/ADDHLD/DATAST cycle counts must be >= 1");
  end
  if (BUSTURN_CYCLES < 0) begin : g_bad_turn_neg
    $error("fsmc_master: BUSTURN_CYCLES must be >= 0");
  end
  if (AD_PAD_W < 0) begin : g_bad_width
    $error("fsmc_master: DATA_WIDTH must not exceed ADDR_WIDTH");
  end

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  fsmc_state_t           state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Registered bus pins and status
  logic                  ne_q, ne_d;
  logic                  nadv_q, nadv_d;
  logic                  nwe_q, nwe_d;
  logic                  noe_q, noe_d;
  logic                  ad_oe_q, ad_oe_d;
  logic [ADDR_WIDTH-1:0] ad_out_q, ad_out_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  // Timer control
  logic                  tmr_load;
  logic [CW-1:0]         tmr_load_val;
  logic                  tmr_done;

  // Read capture
  logic                  accept;
  logic                  rd_last;     // last DATA cycle of a read
  logic                  cap_en;
  logic [DATA_WIDTH-1:0] cap_val;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  fsmc_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk       (clk),
    .rst       (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .done_o    (tmr_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, timer loads, completion
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    rsp_valid_d  = 1'b0;
    rd_last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d         = req_write;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          state_d      = ADDR;
          tmr_load     = 1'b1;
          tmr_load_val = LD_ADDSET;
        end
      end
      ADDR: begin
        if (tmr_done) begin
          state_d      = AHOLD;
          tmr_load     = 1'b1;
          tmr_load_val = LD_ADDHLD;
        end
      end
      AHOLD: begin
        if (tmr_done) begin
          state_d      = DATA;
          tmr_load     = 1'b1;
          tmr_load_val = LD_DATAST;
        end
      end
      DATA: begin
        if (tmr_done) begin
          rd_last = !wr_q;
          if (HAS_TURN) begin
            state_d      = TURN;
            tmr_load     = 1'b1;
            tmr_load_val = LD_BUSTURN;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
          end
        end
      end
      TURN: begin
        if (tmr_done) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the next state so the pin flops line up with
  // the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    ne_d     = 1'b1;
    nadv_d   = 1'b1;
    nwe_d    = 1'b1;
    noe_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = addr_d;
    busy_d   = (state_d != IDLE) || rsp_valid_d;
    unique case (state_d)
      ADDR: begin
        ne_d    = 1'b0;
        nadv_d  = 1'b0;
        ad_oe_d = 1'b1;
      end
      AHOLD: begin
        ne_d    = 1'b0;
        ad_oe_d = 1'b1;
      end
      DATA: begin
        ne_d     = 1'b0;
        ad_out_d = ADDR_WIDTH'(wdata_d);
        if (wr_d) begin
          nwe_d   = 1'b0;
          ad_oe_d = 1'b1;
        end else begin
          noe_d = 1'b0;   // AD stays released while NOE is low
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ne_q        <= 1'b1;
      nadv_q      <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ne_q        <= ne_d;
      nadv_q      <= nadv_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read capture
  // ---------------------------------------------------------------------------
`ifdef FSMC_MASTER_RDSYNC_EN
  // Capturing from the registered AD one cycle late needs a TURN cycle to
  // absorb the extra stage without moving rsp_valid.
  if (BUSTURN_CYCLES < 1) begin : g_rdsync_needs_turn
    $error("fsmc_master: FSMC_MASTER_RDSYNC_EN requires BUSTURN_CYCLES >= 1");
  end

  logic [DATA_WIDTH-1:0] ad_in_q;
  logic                  rd_last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_in_q   <= '0;
      rd_last_q <= 1'b0;
    end else begin
      ad_in_q   <= AD[DATA_WIDTH-1:0];
      rd_last_q <= rd_last;
    end
  end

  assign cap_en  = rd_last_q;
  assign cap_val = ad_in_q;
`else
  assign cap_en  = rd_last;
  assign cap_val = AD[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata_q <= '0;
    end else if (cap_en) begin
      rsp_rdata_q <= cap_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Pins
  // ---------------------------------------------------------------------------
  assign AD        = ad_oe_q ? ad_out_q : {ADDR_WIDTH{1'bz}};
  assign NE        = ne_q;
  assign NADV      = nadv_q;
  assign NWE       = nwe_q;
  assign NOE       = noe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fsmc_master.sv
// -----------------------------------------------------------------------------
// tb_fsmc_master
//   Directed bench for fsmc_master with default timing (ADDSET=2, ADDHLD=1,
//   DATAST=4, BUSTURN=1). Cycle 0 is the acceptance cycle; cycle k is the k-th
//   clock period after it. Outputs are sampled on the falling edge.
//   AD is a pulled-up net, so a released bus reads as all ones.
//   A small target model drives read data while NOE is low and latches
//   address/write data for the loopback check.
//   A second instance with BUSTURN_CYCLES=0 checks the shortened read.
// -----------------------------------------------------------------------------
module tb_fsmc_master;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam logic [AW-1:0] AD_REL = 18'h3FFFF;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_rdata;
  logic          ne, nadv, nwe, noe;
  tri1  [AW-1:0] ad_w;

  fsmc_master dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .NE       (ne),
    .NADV     (nadv),
    .NWE      (nwe),
    .NOE      (noe),
    .AD       (ad_w)
  );

  // Target model: drives read data while NOE is low
  logic          tgt_en;
  logic [DW-1:0] tgt_val;
  assign ad_w = (tgt_en && !noe) ? {2'b00, tgt_val} : {AW{1'bz}};

  // Target capture side: address while NADV low, data while NWE low with the
  // high-address select 2'b01; select clears when NE goes high.
  logic [AW-1:0] tgt_addr;
  logic [DW-1:0] tgt_data;
  logic          tgt_sel;
  always @(negedge clk) begin
    if (!nadv) tgt_addr <= ad_w;
    if (ne) begin
      tgt_sel <= 1'b0;
    end else if (!nwe && tgt_addr[AW-1:AW-2] == 2'b01) begin
      tgt_sel  <= 1'b1;
      tgt_data <= ad_w[DW-1:0];
    end
  end

`ifndef FSMC_MASTER_RDSYNC_EN
  // Zero-turnaround instance
  logic          req_valid2, req_ready2, rsp_valid2, busy2;
  logic [DW-1:0] rsp_rdata2;
  logic          ne2, nadv2, nwe2, noe2;
  tri1  [AW-1:0] ad2_w;
  assign ad2_w = (!noe2) ? 18'h00F0F : {AW{1'bz}};

  fsmc_master #(.BUSTURN_CYCLES(0)) dut_t0 (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid2),
    .req_ready(req_ready2),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2),
    .busy     (busy2),
    .NE       (ne2),
    .NADV     (nadv2),
    .NWE      (nwe2),
    .NOE      (noe2),
    .AD       (ad2_w)
  );
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard / logs
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  logic          ne_l[0:31], nadv_l[0:31], nwe_l[0:31], noe_l[0:31];
  logic          rv_l[0:31], busy_l[0:31], rdy_l[0:31];
  logic [AW-1:0] ad_l[0:31];
  logic [DW-1:0] rd_l[0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents a request in cycle 0 and checks it is accepted.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic hold, input string tag);
    @(negedge clk);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    chk({tag, "_ready_c0"}, req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Logs cycles 1..n; drops req_valid after the edge that ends cycle rel_at.
  task automatic log_cycles(input int n, input int rel_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ne_l[k]   = ne;    nadv_l[k] = nadv;  nwe_l[k] = nwe;  noe_l[k] = noe;
      rv_l[k]   = rsp_valid; busy_l[k] = busy; rdy_l[k] = req_ready;
      ad_l[k]   = ad_w;  rd_l[k] = rsp_rdata;
      if (k == rel_at) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [AW-1:0] exp_ad;
    logic [DW-1:0] exp_rd;
    logic          rv_seen;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    tgt_en = 1'b0; tgt_val = '0;
`ifndef FSMC_MASTER_RDSYNC_EN
    req_valid2 = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ne", ne, 1);     chk("rst_nadv", nadv, 1);
    chk("rst_nwe", nwe, 1);   chk("rst_noe", noe, 1);
    chk("rst_ad", ad_w, AD_REL);
    chk("rst_ready", req_ready, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    #1 chk("rst_ready_after", req_ready, 1);

    // Write 0x10003 <- 0xA55A
    issue(1'b1, 18'h10003, 16'hA55A, 1'b0, "wr");
    log_cycles(10, 0);
    for (int k = 1; k <= 10; k++) begin
      exp_ad = (k <= 3) ? 18'h10003 : (k <= 7) ? 18'h0A55A : AD_REL;
      chk($sformatf("wr_ne_c%0d", k),   ne_l[k],   (k <= 7) ? 0 : 1);
      chk($sformatf("wr_nadv_c%0d", k), nadv_l[k], (k <= 2) ? 0 : 1);
      chk($sformatf("wr_nwe_c%0d", k),  nwe_l[k],  (k >= 4 && k <= 7) ? 0 : 1);
      chk($sformatf("wr_noe_c%0d", k),  noe_l[k],  1);
      chk($sformatf("wr_ad_c%0d", k),   ad_l[k],   exp_ad);
      chk($sformatf("wr_rv_c%0d", k),   rv_l[k],   (k == 9) ? 1 : 0);
      chk($sformatf("wr_busy_c%0d", k), busy_l[k], (k <= 9) ? 1 : 0);
    end
    chk("wr_rdata_unchanged", rd_l[9], 16'h0000);
    chk("wr_tgt_data", tgt_data, 16'hA55A);

    // Read with no target driving: AD must read as released through DATA
    issue(1'b0, 18'h10001, 16'h0000, 1'b0, "rdz");
    log_cycles(10, 0);
    for (int k = 1; k <= 9; k++) begin
      exp_ad = (k <= 3) ? 18'h10001 : AD_REL;
      chk($sformatf("rdz_ad_c%0d", k),  ad_l[k],  exp_ad);
      chk($sformatf("rdz_noe_c%0d", k), noe_l[k], (k >= 4 && k <= 7) ? 0 : 1);
      chk($sformatf("rdz_nwe_c%0d", k), nwe_l[k], 1);
      chk($sformatf("rdz_rv_c%0d", k),  rv_l[k],  (k == 9) ? 1 : 0);
    end
    chk("rdz_rdata", rd_l[9], 16'hFFFF);

    // Read 0x10001 with target driving 0x1234
    tgt_en = 1'b1; tgt_val = 16'h1234;
    exp_q.push_back(16'h1234);
    issue(1'b0, 18'h10001, 16'h0000, 1'b0, "rd");
    log_cycles(10, 0);
    exp_rd = exp_q.pop_front();
    chk("rd_rv_c9", rv_l[9], 1);
    chk("rd_rv_c10", rv_l[10], 0);
    chk("rd_rdata_c9", rd_l[9], exp_rd);
    chk("rd_nadv_c3", nadv_l[3], 1);
    chk("rd_ad_c3", ad_l[3], 18'h10001);

    // Back-to-back: write 0x10004 then read 0x10006, req_valid held high
    tgt_val = 16'hC3C3;
    exp_q.push_back(16'hC3C3);
    issue(1'b1, 18'h10004, 16'h1357, 1'b1, "b2b");
    req_write = 1'b0; req_addr = 18'h10006; req_wdata = 16'hFFFF;
    log_cycles(19, 9);
    exp_rd = exp_q.pop_front();
    chk("b2b_ad_c5_ignored_req", ad_l[5], 18'h01357);
    chk("b2b_ready_c8", rdy_l[8], 0);
    chk("b2b_ready_c9", rdy_l[9], 1);
    chk("b2b_rv_c9", rv_l[9], 1);
    chk("b2b_ne_c7", ne_l[7], 0);
    chk("b2b_ne_c8", ne_l[8], 1);
    chk("b2b_ne_c9", ne_l[9], 1);
    chk("b2b_ne_c10", ne_l[10], 0);
    chk("b2b_nadv_c10", nadv_l[10], 0);
    chk("b2b_ad_c10", ad_l[10], 18'h10006);
    chk("b2b_busy_c10", busy_l[10], 1);
    chk("b2b_noe_c13", noe_l[13], 0);
    chk("b2b_nwe_c13", nwe_l[13], 1);
    chk("b2b_rv_c17", rv_l[17], 0);
    chk("b2b_rv_c18", rv_l[18], 1);
    chk("b2b_rdata_c18", rd_l[18], exp_rd);
    chk("b2b_busy_c19", busy_l[19], 0);

    // Reset during read DATA cycle 2
    tgt_val = 16'h7777;
    issue(1'b0, 18'h10008, 16'h0000, 1'b0, "rst_mid");
    log_cycles(5, 0);
    chk("rst_mid_noe_before", noe_l[5], 0);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_noe", noe, 1);
    chk("rst_mid_ne", ne, 1);
    chk("rst_mid_nwe", nwe, 1);
    chk("rst_mid_nadv", nadv, 1);
    chk("rst_mid_ad", ad_w, AD_REL);
    chk("rst_mid_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen = 1'b1;
    end
    chk("rst_mid_no_rv", rv_seen, 0);
    chk("rst_mid_idle", req_ready, 1);
    exp_q.push_back(16'h7777);
    issue(1'b0, 18'h10008, 16'h0000, 1'b0, "rst_next");
    log_cycles(10, 0);
    exp_rd = exp_q.pop_front();
    chk("rst_next_rv_c9", rv_l[9], 1);
    chk("rst_next_rdata", rd_l[9], exp_rd);

    // Loopback write 0xBEEF to 0x10002; target selects clear afterwards
    tgt_en = 1'b0;
    issue(1'b1, 18'h10002, 16'hBEEF, 1'b0, "lb");
    log_cycles(10, 0);
    chk("lb_tgt_addr", tgt_addr, 18'h10002);
    chk("lb_tgt_data", tgt_data, 16'hBEEF);
    chk("lb_tgt_sel_clear", tgt_sel, 0);
    chk("lb_rdata_held", rsp_rdata, 16'h7777);

`ifndef FSMC_MASTER_RDSYNC_EN
    // BUSTURN_CYCLES=0 read: completion one cycle earlier
    @(negedge clk);
    req_write = 1'b0; req_addr = 18'h10005; req_valid2 = 1'b1;
    chk("t0_ready_c0", req_ready2, 1);
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("t0_rv_c%0d", k), rsp_valid2, (k == 8) ? 1 : 0);
      if (k == 8) begin
        chk("t0_rdata_c8", rsp_rdata2, 16'h0F0F);
        chk("t0_ne_c8", ne2, 1);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmc_master.md
# fsmc_master

- Synchronous FSMC bus initiator for address/data-multiplexed NOR/PSRAM-style transactions, the driving end of the FPGA's FSMC target interface.
- Converts single-beat user read/write requests into timed NE/NADV/NWE/NOE/AD sequences with per-phase cycle counts.
- Used as the initiator in FPGA-to-FPGA links and as the bus model driving target-side verification.
- Returns read data and write completion on a one-cycle response strobe.

## Interface
- ADDR_WIDTH, 18: width of multiplexed AD bus
- DATA_WIDTH, 16: data width; data occupies AD[DATA_WIDTH-1:0]
- ADDSET_CYCLES, 2: cycles NADV low with address driven (≥1)
- ADDHLD_CYCLES, 1: cycles address held after NADV rises (≥1)
- DATAST_CYCLES, 4: cycles NWE/NOE low (≥4 for targets with 2-stage strobe sync)
- BUSTURN_CYCLES, 1: idle cycles after strobe release (0 = skip phase)
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE and not in reset
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  transaction address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  output  DATA_WIDTH  captured read data; held until next read
- busy  output  1  high from acceptance until rsp_valid cycle, inclusive
- NE  output  1  chip enable, low active
- NADV  output  1  address valid, low active
- NWE  output  1  write strobe, low active
- NOE  output  1  read strobe, low active
- AD  inout  ADDR_WIDTH  multiplexed address/data bus

## Operation
- States: IDLE, ADDR, AHOLD, DATA, TURN.
- Request acceptance:
  - Accept on req_valid & req_ready; latch write flag, address and write data.
  - Next state ADDR.
- ADDR: NE=0, NADV=0, AD driven with latched address for ADDSET_CYCLES.
- AHOLD: NADV=1, NE=0, address still driven for ADDHLD_CYCLES.
- DATA, write: NWE=0, AD driven with {zeros, wdata}.
- DATA, read: NOE=0, AD released (high-Z) from first DATA cycle.
- DATA duration: DATAST_CYCLES.
- TURN: NE, NWE, NOE, NADV all 1; AD released for BUSTURN_CYCLES; skipped when 0.
- Completion: return to IDLE with rsp_valid=1 for one cycle.
- Read capture: rsp_rdata ← AD[DATA_WIDTH-1:0] sampled on the last DATA cycle (NOE still low).
- Writes do not change rsp_rdata.
- Never drives AD while NOE is low; AD released whenever not in ADDR/AHOLD/write-DATA.
- All bus outputs and the AD output enable are registered; no combinational path from req_* to bus pins.

## Timing
- Reset values:
  - NE=NADV=NWE=NOE=1, AD high-Z
  - req_ready=0 (1 in first cycle after reset deasserts)
  - rsp_valid=0, rsp_rdata=0, busy=0
- Acceptance at cycle 0 → NE/NADV fall at cycle 1.
- rsp_valid at cycle 1+ADDSET+ADDHLD+DATAST+BUSTURN; defaults: cycle 9.
- Back-to-back: req_ready=1 in the rsp_valid cycle; a request accepted then starts ADDR next cycle.
  - Minimum NE-high gap is 1 cycle (IDLE), plus TURN.
- req_valid deasserted while not ready: ignored, no state change.
- Reset asserted mid-transaction: strobes return high and AD releases immediately (async); no rsp_valid issued; state IDLE.
- Phase counter width: clog2 of the largest phase parameter + 1.
- Counter loads N-1 on phase entry; phase exits when counter reaches 0.

## Configuration
- FSMC_MASTER_RDSYNC_EN defined:
  - AD passes through one input register.
  - Read capture moves to the first cycle after DATA, from the registered AD.
  - BUSTURN_CYCLES forced ≥1 (elaboration error if 0); latency unchanged.
- Not defined: direct capture from AD on the last DATA cycle as above.

## Structure
- Package fsmc_pkg:
  - fsmc_state_t enum (IDLE, ADDR, AHOLD, DATA, TURN)
  - default timing constants
  - localparam for AD zero-extension width
- Sub-module fsmc_phase_timer: loadable down-counter with done flag, one instance shared across phases.

## Test plan
- Write 0x1_0003 data 0xA55A, defaults:
  - NADV low cycles 1–2 with AD=0x10003
  - NWE low cycles 4–7 with AD=0x0A55A
  - rsp_valid at cycle 9
- Read 0x1_0001, target model drives 0x1234 while NOE low:
  - rsp_rdata=0x1234 at rsp_valid cycle 9
  - AD high-Z throughout DATA
- Back-to-back write then read with req_valid held high: second acceptance in first rsp_valid cycle; NE high exactly 2 cycles between transactions.
- Reset pulsed during read DATA cycle 2: NOE=1, NE=1, AD high-Z immediately; no rsp_valid; next read completes normally.
- BUSTURN_CYCLES=0, read: rsp_valid at cycle 8; with FSMC_MASTER_RDSYNC_EN, elaboration fails.
- Loopback against the FSMC target interface (high-address select 2'b01): write 0xBEEF to 0x1_0002 → target captures 0xBEEF and clears its selects.
